sn_decoder_dsc: RTL
===================

Name: sn_decoder_dsc

Overview:
- Converts a deterministic (counter-based) stochastic bitstream back to binary.
- Accumulates ones over one full frame of 2^WIDTH bits and emits the count as a binary value.
- Uses a valid/ready output handshake.
- Sits downstream of the DSC SNG and compute gates (max/min/mult) in the arch-sweep datapath; it closes the binary->stream->binary loop.

Parameters:
- WIDTH, 4, binary precision; frame length is 2^WIDTH bits.
- STRIDE, 1, stream bits consumed per cycle; legal values 1, 2, 4; must divide 2^WIDTH.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  advances frame position and accumulation when high.
- start  input  1  begins a new frame this cycle; the sn_in bits of this cycle are frame bits 0..STRIDE-1.
- sn_in  input  STRIDE  stream bits; sn_in[k] is frame bit (pos+k).
- out_ready  input  1  downstream accepts bin_out.
- bin_out  output  WIDTH+1  ones count of the last completed frame, range 0..2^WIDTH.
- out_valid  output  1  bin_out holds an unconsumed result.
- busy  output  1  a frame is being accumulated.
- overrun  output  1  sticky: a result was overwritten while unconsumed.
- ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, bin_out=0, out_valid=0, busy=0, overrun=0, accumulator=0, position=0.
- Frame length: L=2^WIDTH/STRIDE cycles with en=1. Position counter is log2(L) bits (minimum 1 bit) and counts en-qualified cycles.
- FSM states:
  - IDLE: busy=0. On start&en: acc<=popcount(sn_in), pos<=1, go to ACCUM. If L==1, complete immediately, stay IDLE, publish the result.
  - ACCUM: busy=1. Each en cycle: acc<=acc+popcount(sn_in), pos<=pos+1. With en=0, acc and pos hold.
    - On the en cycle where pos==L-1: publish acc+popcount(sn_in) to bin_out, set out_valid, return to IDLE.
    - If start&en arrives on that final cycle, go to ACCUM with the new frame's first bits. Back-to-back frames have zero bubble.
    - start&en arriving mid-frame (pos!=L-1): discard the partial frame and restart at pos=1 with acc=popcount(sn_in). Nothing is published for the aborted frame.
- Accumulator width is WIDTH+1. An all-ones frame yields exactly 2^WIDTH with no wrap.
- Latency: bin_out/out_valid are registered and visible the cycle after the last frame bit is sampled.
- Handshake:
  - Transfer occurs when out_valid&out_ready; out_valid then drops next cycle unless a new result is published the same cycle.
  - bin_out is stable while out_valid&!out_ready.
  - Publish while out_valid&!out_ready: new value overwrites bin_out, out_valid stays 1, overrun<=1.
  - Publish coincident with a transfer: no overrun; out_valid stays 1 with the new value.
- overrun clears only on ovr_clr=1 or reset. If ovr_clr and a new overrun event coincide, the set wins.
- en=0 freezes the FSM, acc and pos. The output handshake still operates, so downstream may drain while en=0.
- Intended use: the same en as the SNG, with start=SNG ctr_overflow delayed to frame alignment, or a controller pulse.

Decomposition:
- Shared package sn_pkg:
  - state enum {IDLE, ACCUM}.
  - localparam function for frame cycles (2^WIDTH/STRIDE).
  - legal-STRIDE assertion helper.
- Sub-module sn_popcount #(STRIDE): combinational ones count of a STRIDE-bit vector, output width clog2(STRIDE+1). It is also reusable by later stream-statistics blocks.

Test Plan:
- WIDTH=4, STRIDE=1: SNG(bin_in=5) → decoder, start on the SNG counter's wrap, out_ready=1 → out_valid pulses every 16 cycles, bin_out=5.
- WIDTH=4, STRIDE=4: sn_in=4'b1111 held for 4 cycles after start → bin_out=16 (5'b10000), no wrap. sn_in=0 for a frame → bin_out=0.
- WIDTH=4, STRIDE=2, en toggling 50% during a frame of alternating 2'b01 → frame completes after 8 en cycles (≈16 clocks), bin_out=8.
- out_ready=0 across two completed frames (values 3 then 9) → bin_out=9, overrun=1. ovr_clr pulse → overrun=0. Then out_ready=1 → single transfer of 9.
- start reasserted at pos=7 of a WIDTH=4/STRIDE=1 frame → first partial frame never published; next out_valid comes 16 en-cycles after the second start.
- rst asserted mid-ACCUM with out_valid=1 → all outputs 0 immediately (asynchronous). After release, state IDLE, awaits start.

Source files
------------

// File: rtl/sn_pkg.sv
// Shared types and elaboration helpers for the stochastic-number decode blocks.
package sn_pkg;

  // Decoder frame FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sn_state_e;

  // Number of en-qualified cycles needed to consume one 2^width-bit frame.
  function automatic int frame_cycles(input int width, input int stride);
    return (2 ** width) / stride;
  endfunction

  // A stride is usable when it is 1, 2 or 4 and divides the frame length.
  function automatic bit stride_legal(input int width, input int stride);
    return ((stride == 1) || (stride == 2) || (stride == 4)) &&
           (((2 ** width) % stride) == 0);
  endfunction

endpackage

// File: rtl/sn_popcount.sv
// Combinational ones count of a STRIDE-bit vector.
module sn_popcount #(
  parameter int STRIDE = 1,
  parameter int CW     = $clog2(STRIDE + 1)
) (
  input  logic [STRIDE-1:0] bits_i,
  output logic [CW-1:0]     count_o
);

  // Sum the individual bits; STRIDE is tiny so a linear adder chain is fine.
  always_comb begin
    count_o = '0;
    for (int k = 0; k < STRIDE; k++) begin
      count_o = count_o + CW'(bits_i[k]);
    end
  end

endmodule

// File: rtl/sn_decoder_dsc.sv
// Deterministic stochastic-bitstream decoder: counts ones over a 2^WIDTH-bit
// frame and presents the count on a valid/ready output.
//
// Output handshake: a result transfers on any rising edge where
// out_valid && out_ready. bin_out is held while out_valid && !out_ready.
// A new result published while the old one is still unconsumed replaces it
// and sets the sticky overrun flag; a publish on the same edge as a transfer
// is not an overrun. The handshake keeps running while en is low.
//
// rst is asynchronous and active-low.
module sn_decoder_dsc
  import sn_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [STRIDE-1:0] sn_in,
  input  logic              out_ready,
  input  logic              ovr_clr,
  output logic [WIDTH:0]    bin_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  output logic              dbg_state
);

  localparam int L  = frame_cycles(WIDTH, STRIDE);
  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = $clog2(STRIDE + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(L - 1);
  localparam bit SINGLE = (L == 1);

  if (!stride_legal(WIDTH, STRIDE)) begin : g_bad_stride
    $error("sn_decoder_dsc: STRIDE must be 1, 2 or 4 and divide 2^WIDTH");
  end

  sn_state_e      state_q;
  logic [PW-1:0]  pos_q;
  logic [WIDTH:0] acc_q;
  logic [WIDTH:0] bin_q, bin_d;
  logic           valid_q, valid_d;
  logic           ovr_q, ovr_d;

  logic [CW-1:0]  pc;
  logic [WIDTH:0] pc_ext;
  logic [WIDTH:0] acc_sum;
  logic           frame_end;

  sn_popcount #(.STRIDE(STRIDE), .CW(CW)) u_popcount (
    .bits_i  (sn_in),
    .count_o (pc)
  );

  assign pc_ext  = (WIDTH + 1)'(pc);
  assign acc_sum = ((state_q == ACCUM) ? acc_q : '0) + pc_ext;

  // The last bits of a frame are being sampled this cycle.
  assign frame_end = en && (((state_q == ACCUM) && (pos_q == POS_LAST)) ||
                            (SINGLE && (state_q == IDLE) && start));

  // Frame FSM: start (re)opens a frame, en advances it, last position closes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      acc_q   <= '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= pc_ext;
            pos_q   <= PW'(1);
            state_q <= SINGLE ? IDLE : ACCUM;
          end
        end
        ACCUM: begin
          if (start) begin
            acc_q   <= pc_ext;
            pos_q   <= PW'(1);
            state_q <= ACCUM;
          end else if (pos_q == POS_LAST) begin
            acc_q   <= '0;
            pos_q   <= '0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_sum;
            pos_q <= pos_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output handshake next-state: publish wins over transfer, set wins over clear.
  always_comb begin
    bin_d   = bin_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (frame_end) begin
      bin_d   = acc_sum;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (frame_end && valid_q && !out_ready) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bin_out   = bin_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q == ACCUM);
  assign dbg_state = state_q;

endmodule
